la_capture_engine: RTL and testbench

- Parametrised capture core for the logic analyzer.
- Samples CHANNEL_COUNT probe inputs at a programmable rate into a circular buffer, waits for a configurable edge/level trigger, and keeps a fixed pre-trigger window.
- Once the capture completes, it exposes the frozen buffer through a synchronous read port. The VGA renderer indexes that port by display column; index 0 is the oldest sample.

---
 rtl/la_capture_engine_pkg.sv | 21 ++
 rtl/la_trigger_unit.sv | 38 +++
 rtl/la_capture_engine.sv | 203 ++++++++++++++++++++
 tb/tb_la_capture_engine.sv | 250 +++++++++++++++++++++++++
 4 files changed

// File: rtl/la_capture_engine_pkg.sv
// Shared definitions for the logic-analyzer capture core: FSM encoding and default sizing.
package la_capture_engine_pkg;

    typedef enum logic [2:0] {
        StIdle     = 3'd0,
        StPrefill  = 3'd1,
        StWaitTrig = 3'd2,
        StPost     = 3'd3,
        StDone     = 3'd4
    } la_state_e;

    localparam int unsigned DefChannelCount = 10;
    localparam int unsigned DefDepth        = 640;
    localparam int unsigned DefPretrig      = 64;
    localparam int unsigned DefDivWidth     = 16;

    function automatic int unsigned la_addr_width(int unsigned depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/la_trigger_unit.sv
// Combinational trigger evaluation over enabled channels: edge match, level match,
// or a forced trigger when no trigger source is configured.
module la_trigger_unit
    import la_capture_engine_pkg::*;
#(
    parameter int unsigned CHANNEL_COUNT = DefChannelCount
) (
    input  logic [CHANNEL_COUNT-1:0] cur_i,
    input  logic [CHANNEL_COUNT-1:0] prev_i,
    input  logic                     prev_valid_i,
    input  logic [CHANNEL_COUNT-1:0] chan_enable_i,
    input  logic [CHANNEL_COUNT-1:0] trig_rise_mask_i,
    input  logic [CHANNEL_COUNT-1:0] trig_fall_mask_i,
    input  logic [CHANNEL_COUNT-1:0] trig_level_mask_i,
    input  logic [CHANNEL_COUNT-1:0] trig_level_value_i,
    output logic                     trig_o
);

    logic [CHANNEL_COUNT-1:0] rise_m;
    logic [CHANNEL_COUNT-1:0] fall_m;
    logic [CHANNEL_COUNT-1:0] level_m;
    logic                     edge_hit;
    logic                     level_hit;
    logic                     forced;

    always_comb begin
        rise_m    = trig_rise_mask_i & chan_enable_i;
        fall_m    = trig_fall_mask_i & chan_enable_i;
        level_m   = trig_level_mask_i & chan_enable_i;
        // prev is meaningless until it has been loaded once after arm
        edge_hit  = prev_valid_i &&
                    (|((cur_i & ~prev_i & rise_m) | (~cur_i & prev_i & fall_m)));
        level_hit = (level_m != '0) && (((cur_i ^ trig_level_value_i) & level_m) == '0);
        forced    = ((rise_m | fall_m | level_m) == '0);
        trig_o    = edge_hit || level_hit || forced;
    end

endmodule

// File: rtl/la_capture_engine.sv
// Logic-analyzer capture core: synchronised probes sampled into a ring buffer around a
// trigger, then frozen and read out oldest-first through a registered read port.
module la_capture_engine
    import la_capture_engine_pkg::*;
#(
    parameter int unsigned CHANNEL_COUNT = DefChannelCount,
    parameter int unsigned DEPTH         = DefDepth,
    parameter int unsigned PRETRIG       = DefPretrig,
    parameter int unsigned DIV_WIDTH     = DefDivWidth,
    localparam int unsigned AddrW        = la_addr_width(DEPTH)
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,
    input  logic [CHANNEL_COUNT-1:0] probe_i,
    input  logic [CHANNEL_COUNT-1:0] chan_enable_i,
    input  logic                     arm_i,
    input  logic                     abort_i,
    input  logic [DIV_WIDTH-1:0]     sample_div_i,
    input  logic [CHANNEL_COUNT-1:0] trig_rise_mask_i,
    input  logic [CHANNEL_COUNT-1:0] trig_fall_mask_i,
    input  logic [CHANNEL_COUNT-1:0] trig_level_mask_i,
    input  logic [CHANNEL_COUNT-1:0] trig_level_value_i,
    input  logic                     rd_en_i,
    input  logic [AddrW-1:0]         rd_addr_i,
    output logic [CHANNEL_COUNT-1:0] rd_data_o,
    output logic                     rd_valid_o,
    output logic [2:0]               state_o,
    output logic                     busy_o,
    output logic                     done_o
);

    localparam int unsigned CntW       = $clog2(DEPTH + 1);
    localparam logic [CntW-1:0] PreLast  = CntW'(PRETRIG > 0 ? PRETRIG - 1 : 0);
    localparam logic [CntW-1:0] PostLast = CntW'(DEPTH - PRETRIG - 1);
    localparam logic [AddrW-1:0] LastAddr = AddrW'(DEPTH - 1);
    localparam logic [AddrW:0]   DepthX   = (AddrW + 1)'(DEPTH);
    localparam logic [AddrW:0]   PreX     = (AddrW + 1)'(PRETRIG);

    la_state_e                state_q, state_d;
    logic [CHANNEL_COUNT-1:0] sync1_q, sync2_q, prev_q, prev_d, cur;
    logic                     prev_valid_q, prev_valid_d;
    logic [DIV_WIDTH-1:0]     div_q, div_d;
    logic [AddrW-1:0]         wr_ptr_q, wr_ptr_d, trig_addr_q, trig_addr_d;
    logic [AddrW-1:0]         start_addr_q, start_addr_d, wr_ptr_inc, rd_phys;
    logic [CntW-1:0]          cnt_q, cnt_d;
    logic                     active, strobe, arm_ok, trig, we, rd_ok_q, rd_valid_q;
    logic [AddrW:0]           rd_sum;
    logic [CHANNEL_COUNT-1:0] mem_q [DEPTH];
    logic [CHANNEL_COUNT-1:0] rd_raw_q;

    function automatic logic [AddrW-1:0] ring_back_pretrig(logic [AddrW-1:0] a);
        logic [AddrW:0] ax;
        ax = {1'b0, a};
        return (ax >= PreX) ? AddrW'(ax - PreX) : AddrW'(ax + DepthX - PreX);
    endfunction

    assign cur = sync2_q & chan_enable_i;

    la_trigger_unit #(
        .CHANNEL_COUNT(CHANNEL_COUNT)
    ) u_trigger (
        .cur_i             (cur),
        .prev_i            (prev_q),
        .prev_valid_i      (prev_valid_q),
        .chan_enable_i     (chan_enable_i),
        .trig_rise_mask_i  (trig_rise_mask_i),
        .trig_fall_mask_i  (trig_fall_mask_i),
        .trig_level_mask_i (trig_level_mask_i),
        .trig_level_value_i(trig_level_value_i),
        .trig_o            (trig)
    );

    always_comb begin
        active     = (state_q == StPrefill) || (state_q == StWaitTrig) || (state_q == StPost);
        arm_ok     = arm_i && !abort_i && ((state_q == StIdle) || (state_q == StDone));
        strobe     = active && (div_q == sample_div_i);
        wr_ptr_inc = (wr_ptr_q == LastAddr) ? '0 : wr_ptr_q + 1'b1;
    end

    // FSM: state register
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) state_q <= StIdle;
        else         state_q <= state_d;
    end

    // FSM: next state
    always_comb begin
        state_d = state_q;
        if (abort_i) begin
            state_d = StIdle;
        end else begin
            case (state_q)
                StIdle, StDone: if (arm_i) state_d = StPrefill;
                StPrefill: begin
                    if (PRETRIG == 0)                      state_d = StWaitTrig;
                    else if (strobe && (cnt_q == PreLast)) state_d = StWaitTrig;
                end
                StWaitTrig: if (strobe && trig) state_d = (PostLast == '0) ? StDone : StPost;
                StPost:     if (strobe && (cnt_q == PostLast)) state_d = StDone;
                default:    state_d = StIdle;
            endcase
        end
    end

    // FSM: outputs
    always_comb begin
        state_o = state_q;
        busy_o  = active;
        done_o  = (state_q == StDone);
    end

    always_comb begin
        we           = 1'b0;
        prev_d       = prev_q;
        prev_valid_d = prev_valid_q;
        wr_ptr_d     = wr_ptr_q;
        cnt_d        = cnt_q;
        trig_addr_d  = trig_addr_q;
        start_addr_d = start_addr_q;
        div_d        = (!active || strobe) ? '0 : div_q + 1'b1;
        if (strobe) begin
            prev_d       = cur;
            prev_valid_d = 1'b1;
        end
        case (state_q)
            StPrefill: begin
                if (PRETRIG != 0 && strobe) begin
                    we       = 1'b1;
                    wr_ptr_d = wr_ptr_inc;
                    cnt_d    = cnt_q + 1'b1;
                end
            end
            StWaitTrig: begin
                if (strobe) begin
                    we       = 1'b1;
                    wr_ptr_d = wr_ptr_inc;
                    if (trig) begin
                        trig_addr_d = wr_ptr_q;
                        cnt_d       = CntW'(1);
                    end
                end
            end
            StPost: begin
                if (strobe) begin
                    we       = 1'b1;
                    wr_ptr_d = wr_ptr_inc;
                    cnt_d    = cnt_q + 1'b1;
                end
            end
            default: ;
        endcase
        if (arm_ok) begin
            wr_ptr_d     = '0;
            cnt_d        = '0;
            div_d        = '0;
            prev_valid_d = 1'b0;
        end
        if (state_d == StDone && state_q != StDone) start_addr_d = ring_back_pretrig(trig_addr_d);
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sync1_q      <= '0;
            sync2_q      <= '0;
            prev_q       <= '0;
            prev_valid_q <= 1'b0;
            div_q        <= '0;
            wr_ptr_q     <= '0;
            cnt_q        <= '0;
            trig_addr_q  <= '0;
            start_addr_q <= '0;
            rd_valid_q   <= 1'b0;
            rd_ok_q      <= 1'b0;
        end else begin
            sync1_q      <= probe_i;
            sync2_q      <= sync1_q;
            prev_q       <= prev_d;
            prev_valid_q <= prev_valid_d;
            div_q        <= div_d;
            wr_ptr_q     <= wr_ptr_d;
            cnt_q        <= cnt_d;
            trig_addr_q  <= trig_addr_d;
            start_addr_q <= start_addr_d;
            rd_valid_q   <= rd_en_i;
            rd_ok_q      <= rd_en_i && (state_q == StDone) && ({1'b0, rd_addr_i} < DepthX);
        end
    end

    // Logical index 0 maps to the oldest sample in the frozen ring
    always_comb begin
        rd_sum  = {1'b0, start_addr_q} + {1'b0, rd_addr_i};
        rd_phys = (rd_sum >= DepthX) ? AddrW'(rd_sum - DepthX) : AddrW'(rd_sum);
    end

    always_ff @(posedge clk_i) begin
        if (we)      mem_q[wr_ptr_q] <= cur;
        if (rd_en_i) rd_raw_q        <= mem_q[rd_phys];
    end

    assign rd_valid_o = rd_valid_q;
    assign rd_data_o  = rd_ok_q ? rd_raw_q : '0;

endmodule

// File: tb/tb_la_capture_engine.sv
// Directed bench for la_capture_engine (4 channels, 16-deep, 4 pre-trigger samples).
module tb_la_capture_engine;

    localparam int unsigned Ch    = 4;
    localparam int unsigned Depth = 16;
    localparam int unsigned Pre   = 4;
    localparam int unsigned DivW  = 16;

    logic            clk = 1'b0;
    logic            rst_n;
    logic [Ch-1:0]   probe, chan_enable, rise_mask, fall_mask, level_mask, level_value;
    logic            arm, abort, rd_en, rd_valid, busy, done;
    logic [DivW-1:0] sample_div;
    logic [3:0]      rd_addr;
    logic [Ch-1:0]   rd_data;
    logic [2:0]      state;

    int errors = 0;
    int checks = 0;
    bit count_en = 1'b0;

    always #5 clk = ~clk;

    la_capture_engine #(
        .CHANNEL_COUNT(Ch),
        .DEPTH        (Depth),
        .PRETRIG      (Pre),
        .DIV_WIDTH    (DivW)
    ) dut (
        .clk_i             (clk),
        .rst_ni            (rst_n),
        .probe_i           (probe),
        .chan_enable_i     (chan_enable),
        .arm_i             (arm),
        .abort_i           (abort),
        .sample_div_i      (sample_div),
        .trig_rise_mask_i  (rise_mask),
        .trig_fall_mask_i  (fall_mask),
        .trig_level_mask_i (level_mask),
        .trig_level_value_i(level_value),
        .rd_en_i           (rd_en),
        .rd_addr_i         (rd_addr),
        .rd_data_o         (rd_data),
        .rd_valid_o        (rd_valid),
        .state_o           (state),
        .busy_o            (busy),
        .done_o            (done)
    );

    // Inputs change 1ns after the rising edge; the probe optionally counts once per clock.
    task automatic tick();
        @(posedge clk);
        #1;
        if (count_en) probe = probe + 1'b1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic read_chk(input string tag, input int addr, input logic [Ch-1:0] exp);
        rd_en   = 1'b1;
        rd_addr = 4'(addr);
        tick();
        rd_en = 1'b0;
        check($sformatf("%s_valid[%0d]", tag, addr), 32'(rd_valid), 32'd1);
        check($sformatf("%s_data[%0d]", tag, addr), 32'(rd_data), 32'(exp));
    endtask

    // Arm lands one clock after the call starts, so a counting probe reset to 0 just
    // before this call makes the first stored sample exactly 0.
    task automatic start_capture();
        tick();
        arm = 1'b1;
        tick();
        arm = 1'b0;
    endtask

    task automatic wait_done(input string tag, input int budget);
        int n = 0;
        while (done !== 1'b1 && n < budget) begin
            tick();
            n++;
        end
        check(tag, 32'(done), 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n       = 1'b0;
        probe       = '0;
        chan_enable = 4'hF;
        rise_mask   = '0;
        fall_mask   = '0;
        level_mask  = '0;
        level_value = '0;
        arm         = 1'b0;
        abort       = 1'b0;
        rd_en       = 1'b0;
        rd_addr     = '0;
        sample_div  = '0;

        // Reset
        repeat (3) @(posedge clk);
        #1;
        check("rst_state_held", 32'(state), 32'd0);
        rst_n = 1'b1;
        tick();
        check("rst_state", 32'(state), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_rd_valid", 32'(rd_valid), 32'd0);
        read_chk("idle_rd", 0, 4'h0);
        tick();
        check("rd_valid_drop", 32'(rd_valid), 32'd0);

        // Rising trigger on bit 2: samples 0..3 prefill, 4 triggers (3 -> 4)
        rise_mask = 4'b0100;
        probe     = '0;
        count_en  = 1'b1;
        start_capture();
        check("prefill_state", 32'(state), 32'd1);
        check("prefill_busy", 32'(busy), 32'd1);
        wait_done("rise_done", 40);
        count_en = 1'b0;
        check("rise_busy_off", 32'(busy), 32'd0);
        for (int i = 0; i < 5; i++) read_chk("rise", i, 4'(i));
        read_chk("rise", 9, 4'd9);
        read_chk("rise", 15, 4'd15);

        // Falling trigger on bit 0, re-armed from DONE; the 1 -> 2 fall lies in prefill
        rise_mask = '0;
        fall_mask = 4'b0001;
        probe     = '0;
        count_en  = 1'b1;
        start_capture();
        wait_done("fall_done", 40);
        count_en = 1'b0;
        read_chk("fall", 2, 4'd2);
        read_chk("fall", 3, 4'd3);
        read_chk("fall", 4, 4'd4);
        read_chk("fall", 15, 4'd15);

        // Divider 3, forced trigger: one strobe per 4 clocks, 16 strobes to DONE
        fall_mask  = '0;
        sample_div = 16'd3;
        probe      = '0;
        count_en   = 1'b1;
        start_capture();
        repeat (63) tick();
        check("div_not_done", 32'(done), 32'd0);
        check("div_busy", 32'(busy), 32'd1);
        tick();
        check("div_done", 32'(done), 32'd1);
        count_en   = 1'b0;
        sample_div = '0;
        read_chk("div", 0, 4'd3);
        read_chk("div", 1, 4'd7);
        read_chk("div", 4, 4'd3);
        read_chk("div", 6, 4'd11);
        read_chk("div", 15, 4'd15);

        // Abort during POST (forced trigger, constant probe)
        probe = '0;
        start_capture();
        repeat (4) tick();
        check("forced_wait", 32'(state), 32'd2);
        tick();
        check("forced_post", 32'(state), 32'd3);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        check("abort_state", 32'(state), 32'd0);
        check("abort_done", 32'(done), 32'd0);
        check("abort_busy", 32'(busy), 32'd0);
        read_chk("idle_gate", 4, 4'h0);

        // arm and abort together in IDLE
        arm   = 1'b1;
        abort = 1'b1;
        tick();
        arm   = 1'b0;
        abort = 1'b0;
        check("arm_abort_idle", 32'(state), 32'd0);
        tick();
        check("arm_abort_idle2", 32'(state), 32'd0);

        // arm ignored while waiting for a trigger that never comes
        rise_mask = 4'b1000;
        start_capture();
        repeat (4) tick();
        check("wait_state", 32'(state), 32'd2);
        arm = 1'b1;
        tick();
        arm = 1'b0;
        check("arm_in_wait", 32'(state), 32'd2);
        tick();
        check("arm_in_wait2", 32'(state), 32'd2);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        check("abort_wait", 32'(state), 32'd0);

        // Level trigger with channel 3 disabled
        rise_mask   = '0;
        level_mask  = 4'b1001;
        level_value = 4'b1001;
        chan_enable = 4'b0111;
        probe       = 4'b1001;
        repeat (3) tick();
        start_capture();
        repeat (15) tick();
        check("level_post", 32'(state), 32'd3);
        tick();
        check("level_done", 32'(state), 32'd4);
        read_chk("level", 0, 4'b0001);
        read_chk("level", 4, 4'b0001);
        read_chk("level", 15, 4'b0001);

        // Asynchronous reset mid-capture
        level_mask  = '0;
        level_value = '0;
        chan_enable = 4'hF;
        start_capture();
        repeat (5) tick();
        check("pre_reset_post", 32'(state), 32'd3);
        #2 rst_n = 1'b0;
        #1;
        check("async_rst_state", 32'(state), 32'd0);
        check("async_rst_busy", 32'(busy), 32'd0);
        rst_n = 1'b1;
        tick();
        check("post_rst_state", 32'(state), 32'd0);
        check("post_rst_done", 32'(done), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
